// File: rtl/usb_pulpino_word_sender_if.sv
// Word push bus from the USB register block into the PULPino word sender.
// master: USB register side (drives word_i / word_valid_i, sees word_ready_o).
// slave : word sender (captures word_i on word_valid_i, reports word_ready_o).
interface usb_pulpino_word_sender_if #(
  parameter int pWORD_WIDTH = 32
);
  logic [pWORD_WIDTH-1:0] word_i;
  logic                   word_valid_i;
  logic                   word_ready_o;

  modport master (
    output word_i,
    output word_valid_i,
    input  word_ready_o
  );

  modport slave (
    input  word_i,
    input  word_valid_i,
    output word_ready_o
  );
endinterface

// File: rtl/usb_pulpino_word_sender.sv
// Purpose : buffers 32-bit words from the USB register block and serializes them
//           LSB-byte-first onto the PULPino GPIO byte lane via a 2-bit turn handshake.
// Latency : push at edge E0 -> first byte/turn visible after E2; ack -> next byte in 1 cycle.
// Backpressure: word_ready_o drops when the FIFO is full; a push while full is dropped
//           and flagged on the sticky overflow_o. PULPino paces bytes through its turn counter.
// Ports   : clk, reset_i (sync, active high); word_if (slave: word_i, word_valid_i,
//           word_ready_o); flush_i; gpio_data_in_o; data_in_io_turn_o; data_in_pulpino_turn_i;
//           data_in_done_o; fifo_level_o; overflow_o; proto_err_o.
// Option  : define PULPINO_TURN_SYNC_EN to pass data_in_pulpino_turn_i through a
//           2-flop synchronizer (adds 2 cycles to ack and protocol-check latency).
module usb_pulpino_word_sender #(
  parameter int pWORD_WIDTH = 32,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_i,
  usb_pulpino_word_sender_if.slave     word_if,
  input  logic                         flush_i,
  output logic [7:0]                   gpio_data_in_o,
  output logic [1:0]                   data_in_io_turn_o,
  input  logic [1:0]                   data_in_pulpino_turn_i,
  output logic                         data_in_done_o,
  output logic [$clog2(pFIFO_DEPTH):0] fifo_level_o,
  output logic                         overflow_o,
  output logic                         proto_err_o
);

  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int NB = pWORD_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, DONE} state_t;

  logic [pWORD_WIDTH-1:0] r_mem [pFIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;

  state_t                 r_state;
  logic [pWORD_WIDTH-1:0] r_shreg;
  logic [BW-1:0]          r_byte_cnt;
  logic [7:0]             r_gpio;
  logic [1:0]             r_io_turn;
  logic                   r_done;
  logic                   r_proto_err;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [1:0]             w_pturn;
  logic                   w_ack;
  logic                   w_last;
  logic [pWORD_WIDTH-1:0] w_shreg_next;

`ifdef PULPINO_TURN_SYNC_EN
  logic [1:0] r_pturn_meta;
  logic [1:0] r_pturn_sync;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_pturn_meta <= 2'b00;
      r_pturn_sync <= 2'b00;
    end else begin
      r_pturn_meta <= data_in_pulpino_turn_i;
      r_pturn_sync <= r_pturn_meta;
    end
  end

  assign w_pturn = r_pturn_sync;
`else
  assign w_pturn = data_in_pulpino_turn_i;
`endif

  assign w_full       = (r_count == (AW+1)'(pFIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  // Full is the pre-edge state, so a same-cycle pop never rescues a push.
  assign w_push       = word_if.word_valid_i && !w_full && !flush_i;
  assign w_pop        = (r_state == IDLE) && !w_empty;
  assign w_ack        = (w_pturn == r_io_turn);
  assign w_last       = (r_byte_cnt == BW'(NB - 1));
  assign w_shreg_next = r_shreg >> 8;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= word_if.word_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A flush swallows a simultaneous push silently, so no overflow then.
      if (word_if.word_valid_i && w_full && !flush_i) begin
        r_overflow <= 1'b1;
      end
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_byte_cnt  <= '0;
      r_gpio      <= 8'h00;
      r_io_turn   <= 2'b00;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_ack) r_proto_err <= 1'b1;
          if (!w_empty) begin
            r_shreg    <= r_mem[r_rd_ptr];
            r_byte_cnt <= '0;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_gpio    <= r_shreg[7:0];
          r_io_turn <= r_io_turn + 2'd1;
          r_state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // PULPino may legally lag by exactly one turn while a byte is outstanding.
          if (!w_ack && (w_pturn != r_io_turn - 2'd1)) r_proto_err <= 1'b1;
          if (w_ack) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_shreg    <= w_shreg_next;
              r_gpio     <= w_shreg_next[7:0];
              r_byte_cnt <= r_byte_cnt + BW'(1);
              r_io_turn  <= r_io_turn + 2'd1;
            end
          end
        end
        DONE: begin
          if (!w_ack) r_proto_err <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign word_if.word_ready_o = !w_full;
  assign gpio_data_in_o       = r_gpio;
  assign data_in_io_turn_o    = r_io_turn;
  assign data_in_done_o       = r_done;
  assign fifo_level_o         = r_count;
  assign overflow_o           = r_overflow;
  assign proto_err_o          = r_proto_err;

endmodule

// File: doc/usb_pulpino_word_sender.md
Name: usb_pulpino_word_sender

Overview:
- Downstream of the USB register block, in the PULPino clock domain.
- Accepts 32-bit words captured from the USB register interface (do_read strobe) into a small word FIFO.
- Serializes each word LSB-byte-first onto the PULPino GPIO input byte lane using the 2-bit turn-counter handshake polled by PULPino software.
- Pulses a done strobe once the whole word has been consumed.

Parameters:
pWORD_WIDTH, 32, input word width; must be a multiple of 8 (bytes per word = pWORD_WIDTH/8).
pFIFO_DEPTH, 4, word FIFO depth; power of 2, >= 2.

Ports:
clk  in  1  PULPino clock; all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
word_i  in  pWORD_WIDTH  word from the USB register block.
word_valid_i  in  1  single-cycle write strobe (do_read).
word_ready_o  out  1  FIFO not full.
flush_i  in  1  clears FIFO contents; does not touch the in-flight word.
gpio_data_in_o  out  8  byte presented to PULPino gpio_in[7:0].
data_in_io_turn_o  out  2  sender turn counter, to gpio_in[9:8].
data_in_pulpino_turn_i  in  2  PULPino ack turn counter, from gpio_out[9:8].
data_in_done_o  out  1  one-cycle pulse when the last byte of a word is acked.
fifo_level_o  out  clog2(pFIFO_DEPTH)+1  words buffered, excluding the in-flight word.
overflow_o  out  1  sticky; set when a push is dropped.
proto_err_o  out  1  sticky; illegal PULPino turn value seen.

Behaviour:
- Reset: FIFO empty, state IDLE, shift register 0.
  - All outputs 0, except word_ready_o = 1 (FIFO empty).
  - io_turn = 2'b00; overflow_o = 0; proto_err_o = 0.
- Push: word_valid_i && !full writes the FIFO at that edge.
  - word_valid_i while full: the word is dropped and overflow_o is set.
  - full is the pre-edge state, so a simultaneous pop does not rescue a push when full.
- Pop and push in the same cycle when not full: both happen; level unchanged.
- flush_i: level goes to 0 at the edge. flush has priority over a simultaneous push (push is discarded, overflow not set). The in-flight word completes normally.
- Handshake:
  - A byte is outstanding while io_turn != pulpino_turn.
  - Byte and io_turn update on the same edge; the byte is held until acked.
  - Ack = pulpino_turn == io_turn.
  - Turn arithmetic is mod 4; 3 wraps to 0.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop into the shift register, byte_cnt = 0, go to LOAD.
  - LOAD: drive gpio_data_in_o = shreg[7:0], io_turn += 1, go to WAIT_ACK.
  - WAIT_ACK on ack, last byte (byte_cnt == pWORD_WIDTH/8 - 1): go to DONE.
  - WAIT_ACK on ack, not last byte: shift the shift register right by 8, byte_cnt += 1, drive the next byte, io_turn += 1, stay in WAIT_ACK.
  - DONE: data_in_done_o = 1 for exactly this cycle, go to IDLE.
- Latency:
  - word_valid_i sampled at edge E0 → first byte and turn visible after E2.
  - Ack sampled → next byte and turn visible after the same edge (1 cycle).
  - Back-to-back words: IDLE→LOAD adds 2 cycles after DONE.
- Protocol check:
  - In WAIT_ACK, pulpino_turn not in {io_turn, io_turn-1} sets proto_err_o; FSM keeps waiting.
  - In IDLE/DONE, pulpino_turn != io_turn sets proto_err_o.
- gpio_data_in_o holds its last byte when idle.
- Reset mid-word: immediate return to the reset state; no done pulse.

Optional Feature:
- PULPINO_TURN_SYNC_EN defined:
  - data_in_pulpino_turn_i passes through a 2-flop synchronizer (reset to 00) before use.
  - Ack latency and protocol-check latency each grow by 2 cycles.
- Undefined: the input is used directly, same-clock assumption.

Test Plan:
- Reset: hold reset_i 3 cycles → all outputs 0 except word_ready_o = 1; level 0; io_turn 00.
- Single word 0xA1B2C3D4, bench acks 3 cycles after each turn change:
  - bytes D4, C3, B2, A1 with io_turn 1, 2, 3, 0;
  - data_in_done_o pulses exactly once, after the 4th ack;
  - fifo_level_o returns to 0.
- Six back-to-back pushes, no acks (pFIFO_DEPTH = 4):
  - 5 accepted (1 in flight + 4 buffered); level 4; word_ready_o = 0;
  - 6th dropped; overflow_o = 1;
  - after acking, exactly 5 done pulses in push order.
- Turn wrap: 2 words, 8 acks → io_turn sequence 1, 2, 3, 0, 1, 2, 3, 0; 2 done pulses; proto_err_o stays 0.
- Protocol error: in WAIT_ACK with io_turn = 1, drive pulpino_turn = 2 → proto_err_o = 1 next edge; byte held; a correct ack of 1 still advances.
- Reset mid-word: after 2 bytes acked, pulse reset_i → all outputs back to reset values, FIFO empty, no done pulse; a new word restarts at io_turn 1.
